// File: rtl/lsu_datamem_master.sv
// ---------------------------------------------------------------------------
// lsu_datamem_master
//
// Load/store initiator between the core's memory stage and a data memory
// with a one-cycle registered read port. One request is in flight at a time.
// Each request is checked for a legal funct3, natural alignment and address
// range. Legal requests drive a single memory access. Load data is extended
// according to funct3. Every accepted request ends in a one-cycle response
// carrying the data and an error code.
//
// Handshake: a request transfers on a rising edge where LSU_Req_Valid and
// LSU_Req_Ready are both 1. Ready is 1 only in IDLE. Valid seen while not
// ready is ignored and never queued. The response is a single-cycle
// LSU_Resp_Valid pulse with no back-pressure. On the memory side, a read
// is taken when LSU_Mem_Re and LSU_Mem_Read_Valid are both 1, and a write
// is taken when LSU_Mem_We and LSU_Mem_Write_Ready are both 1. Re or We
// stays asserted until the memory acknowledges.
//
// Ports:
//   LSU_Clk, LSU_Reset      clock, synchronous active-high reset
//   LSU_Req_*               request: valid/ready, store, funct3, addr, wdata
//   LSU_Resp_*              response: valid pulse, data, err
//                           (00 ok, 01 misaligned, 10 range, 11 funct3)
//   LSU_Mem_*               data memory port: We, Re, Byteenable, Address,
//                           Data_In, Data_Out, Read_Valid, Write_Ready
//   LSU_Dbg_State           current FSM state (debug observation)
// ---------------------------------------------------------------------------
module lsu_datamem_master #(
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                     LSU_Clk,
    input  logic                     LSU_Reset,
    input  logic                     LSU_Req_Valid,
    output logic                     LSU_Req_Ready,
    input  logic                     LSU_Req_Store,
    input  logic [2:0]               LSU_Req_Funct3,
    input  logic [31:0]              LSU_Req_Addr,
    input  logic [31:0]              LSU_Req_Wdata,
    output logic                     LSU_Resp_Valid,
    output logic [31:0]              LSU_Resp_Data,
    output logic [1:0]               LSU_Resp_Err,
    output logic                     LSU_Mem_We,
    output logic                     LSU_Mem_Re,
    output logic [3:0]               LSU_Mem_Byteenable,
    output logic [ADDR_BITWIDTH-1:0] LSU_Mem_Address,
    output logic [31:0]              LSU_Mem_Data_In,
    input  logic [31:0]              LSU_Mem_Data_Out,
    input  logic                     LSU_Mem_Read_Valid,
    input  logic                     LSU_Mem_Write_Ready,
    output logic [2:0]               LSU_Dbg_State
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [2:0]               r_funct3;
    logic [ADDR_BITWIDTH-1:0] r_addr;
    logic [31:0]              r_wdata;
    logic [31:0]              r_resp_data;
    logic [1:0]               r_resp_err;

    logic                     w_illegal;
    logic                     w_misaligned;
    logic                     w_out_of_range;
    logic [1:0]               w_req_err;
    logic [3:0]               w_be;
    logic [31:0]              w_store_data;
    logic [31:0]              w_load_ext;
    logic                     w_accept;

    assign w_accept = (r_state == S_IDLE) && LSU_Req_Valid;

    // Classification looks at the live request inputs in the accept cycle,
    // so the error is already known when the request is latched.
    always_comb begin
        if (LSU_Req_Store) begin
            w_illegal = LSU_Req_Funct3[2] || (LSU_Req_Funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (LSU_Req_Funct3 == 3'b011) || (LSU_Req_Funct3 == 3'b110)
                     || (LSU_Req_Funct3 == 3'b111);
        end
        w_misaligned = ((LSU_Req_Funct3[1:0] == 2'b01) && LSU_Req_Addr[0])
                    || ((LSU_Req_Funct3[1:0] == 2'b10) && (LSU_Req_Addr[1:0] != 2'b00));
        w_out_of_range = (LSU_Req_Addr >> ADDR_BITWIDTH) != 32'd0;
        if (w_illegal) begin
            w_req_err = 2'b11;
        end else if (w_misaligned) begin
            w_req_err = 2'b01;
        end else if (w_out_of_range) begin
            w_req_err = 2'b10;
        end else begin
            w_req_err = 2'b00;
        end
    end

    // Size decode from the latched request. Code 11 never reaches RD/WR.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   begin w_be = 4'b0001; w_store_data = {24'd0, r_wdata[7:0]};  end
            2'b01:   begin w_be = 4'b0011; w_store_data = {16'd0, r_wdata[15:0]}; end
            default: begin w_be = 4'b1111; w_store_data = r_wdata;               end
        endcase
    end

    // The memory returns the addressed lanes right-aligned and zero-extended.
    // Only sign handling is left to do here.
    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{24{LSU_Mem_Data_Out[7]}},  LSU_Mem_Data_Out[7:0]};
            3'b001:  w_load_ext = {{16{LSU_Mem_Data_Out[15]}}, LSU_Mem_Data_Out[15:0]};
            3'b100:  w_load_ext = {24'd0, LSU_Mem_Data_Out[7:0]};
            3'b101:  w_load_ext = {16'd0, LSU_Mem_Data_Out[15:0]};
            default: w_load_ext = LSU_Mem_Data_Out;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (LSU_Req_Valid) begin
                    if (w_req_err != 2'b00) begin
                        w_next = S_RESP;
                    end else if (LSU_Req_Store) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:      if (LSU_Mem_Read_Valid)  w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_RESP;
            S_WR:      if (LSU_Mem_Write_Ready) w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // All handshake and memory outputs are forced low while reset is high.
    // An access in flight is therefore dropped in the same cycle that reset
    // appears, not one cycle later.
    always_comb begin
        LSU_Req_Ready      = 1'b0;
        LSU_Resp_Valid     = 1'b0;
        LSU_Mem_We         = 1'b0;
        LSU_Mem_Re         = 1'b0;
        LSU_Mem_Byteenable = 4'b0000;
        LSU_Mem_Address    = '0;
        LSU_Mem_Data_In    = 32'd0;
        if (!LSU_Reset) begin
            case (r_state)
                S_IDLE: LSU_Req_Ready = 1'b1;
                S_RD: begin
                    LSU_Mem_Re         = 1'b1;
                    LSU_Mem_Byteenable = w_be;
                    LSU_Mem_Address    = r_addr;
                end
                S_WR: begin
                    LSU_Mem_We         = 1'b1;
                    LSU_Mem_Byteenable = w_be;
                    LSU_Mem_Address    = r_addr;
                    LSU_Mem_Data_In    = w_store_data;
                end
                S_RESP:  LSU_Resp_Valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge LSU_Clk) begin
        if (LSU_Reset) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3 <= LSU_Req_Funct3;
                r_addr   <= LSU_Req_Addr[ADDR_BITWIDTH-1:0];
                r_wdata  <= LSU_Req_Wdata;
                if (w_req_err != 2'b00) begin
                    r_resp_data <= 32'd0;
                    r_resp_err  <= w_req_err;
                end
            end
            if (r_state == S_RD_WAIT) begin
                r_resp_data <= w_load_ext;
                r_resp_err  <= 2'b00;
            end
            if ((r_state == S_WR) && LSU_Mem_Write_Ready) begin
                r_resp_data <= 32'd0;
                r_resp_err  <= 2'b00;
            end
        end
    end

    assign LSU_Resp_Data = r_resp_data;
    assign LSU_Resp_Err  = r_resp_err;
    assign LSU_Dbg_State = r_state;

endmodule

// File: tb/tb_lsu_datamem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_datamem_master
//
// Directed bench for lsu_datamem_master. The bench contains:
//  - a byte-array data memory device with a one-cycle registered read port;
//  - a reference model that works out, from the request alone, each
//    response's data, error code, arrival cycle and memory beats;
//  - a per-cycle compare process;
//  - literal checks on the responses of the directed vectors.
// ---------------------------------------------------------------------------
module tb_lsu_datamem_master;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_f3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_data;
    logic [1:0]    resp_err;
    logic          mem_we;
    logic          mem_re;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = 32'd0;
    logic          rd_ready;
    logic          wr_ready;
    logic [2:0]    dbg_state;

    lsu_datamem_master #(.ADDR_BITWIDTH(AW)) dut (
        .LSU_Clk             (clk),
        .LSU_Reset           (rst),
        .LSU_Req_Valid       (req_valid),
        .LSU_Req_Ready       (req_ready),
        .LSU_Req_Store       (req_store),
        .LSU_Req_Funct3      (req_f3),
        .LSU_Req_Addr        (req_addr),
        .LSU_Req_Wdata       (req_wdata),
        .LSU_Resp_Valid      (resp_valid),
        .LSU_Resp_Data       (resp_data),
        .LSU_Resp_Err        (resp_err),
        .LSU_Mem_We          (mem_we),
        .LSU_Mem_Re          (mem_re),
        .LSU_Mem_Byteenable  (mem_be),
        .LSU_Mem_Address     (mem_addr),
        .LSU_Mem_Data_In     (mem_din),
        .LSU_Mem_Data_Out    (mem_dout),
        .LSU_Mem_Read_Valid  (rd_ready),
        .LSU_Mem_Write_Ready (wr_ready),
        .LSU_Dbg_State       (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d, state %0d)", name, act, exp, cyc, dbg_state);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d, state %0d)", name, cyc, dbg_state);
    endtask

    // ---------------- initial memory image ----------------
    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] w20;
        logic [31:0] w30;
        w20 = 32'h80FF7F81;
        w30 = 32'h11223344;
        case (i / 4)
            8:       return w20[8*(i%4) +: 8];
            12:      return w30[8*(i%4) +: 8];
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- data memory device ----------------
    logic [7:0] dev_mem [0:1023];
    always @(posedge clk) begin
        int a;
        a = int'(mem_addr);
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) dev_mem[i] <= init_byte(i);
        end else begin
            if (mem_re && rd_ready) begin
                case (mem_be)
                    4'b0001: mem_dout <= {24'd0, dev_mem[a]};
                    4'b0011: mem_dout <= {16'd0, dev_mem[(a+1)%1024], dev_mem[a]};
                    default: mem_dout <= {dev_mem[(a+3)%1024], dev_mem[(a+2)%1024],
                                          dev_mem[(a+1)%1024], dev_mem[a]};
                endcase
            end
            if (mem_we && wr_ready) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) dev_mem[(a+i)%1024] <= mem_din[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  err;
        int          due;
        int          n_we;
        int          n_re;
        logic [3:0]  be;
        logic [31:0] din;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [0:1023];
    bit         ref_loaded = 1'b0;

    // Fills in everything except the absolute due cycle. The latency is left in 'due'.
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input int stall);
        exp_t        e;
        int          size;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mask  = 32'hFFFF_FFFF >> (32 - 8*size);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.st   = st;
        e.addr = addr;
        e.data = 32'd0;
        e.n_we = 0;
        e.n_re = 0;
        e.be   = 4'((1 << size) - 1);
        e.din  = wd & mask;
        if (!legal)                        e.err = 2'b11;
        else if ((addr % size) != 0)       e.err = 2'b01;
        else if (addr >= 32'(1 << AW))     e.err = 2'b10;
        else                               e.err = 2'b00;
        if (e.err != 2'b00) begin
            e.due = 1;
        end else if (st) begin
            e.due  = 2 + stall;
            e.n_we = 1 + stall;
        end else begin
            e.due  = 3 + stall;
            e.n_re = 1 + stall;
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            e.data = v;
        end
        return e;
    endfunction

    // ---------------- compare process ----------------
    logic [31:0] last_data;
    logic [1:0]  last_err;
    int          done_cnt = 0;
    int          we_seen  = 0;
    int          re_seen  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!ref_loaded) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
            ref_loaded = 1'b1;
        end
        if (rst) begin
            check("reset_outputs",
                  {req_ready, mem_we, mem_re, mem_be, 10'(mem_addr), mem_din, resp_valid}, 64'd0);
            we_seen = 0;
            re_seen = 0;
        end else begin
            check("we_re_exclusive", 64'(mem_we & mem_re), 64'd0);
            check("req_ready", 64'(req_ready), 64'(exp_q.size() == 0));
            if (mem_we) begin
                we_seen++;
                if (exp_q.size() == 0 || !exp_q[0].st || exp_q[0].err != 2'b00)
                    fail_now("we_unexpected");
                else
                    check("we_port", {mem_be, 10'(mem_addr), mem_din},
                          {exp_q[0].be, 10'(exp_q[0].addr), exp_q[0].din});
            end
            if (mem_re) begin
                re_seen++;
                if (exp_q.size() == 0 || exp_q[0].st || exp_q[0].err != 2'b00)
                    fail_now("re_unexpected");
                else
                    check("re_port", {mem_be, 10'(mem_addr), mem_din},
                          {exp_q[0].be, 10'(exp_q[0].addr), 32'd0});
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", 64'(resp_data), 64'(e.data));
                    check("resp_err", 64'(resp_err), 64'(e.err));
                    check("resp_cycle", 64'(cyc), 64'(e.due));
                    check("we_beats", 64'(we_seen), 64'(e.n_we));
                    check("re_beats", 64'(re_seen), 64'(e.n_re));
                    if (e.st && e.err == 2'b00)
                        for (int i = 0; i < 4; i++)
                            if (e.be[i]) ref_mem[e.addr + i] = e.din[8*i +: 8];
                    last_data = resp_data;
                    last_err  = resp_err;
                    done_cnt++;
                end
                we_seen = 0;
                re_seen = 0;
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                fail_now("resp_timeout");
                void'(exp_q.pop_front());
                done_cnt++;
                we_seen = 0;
                re_seen = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        for (int k = 0; k < 20 && !req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        if (!req_ready) fail_now("ready_timeout");
    endtask

    task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int stall,
                          input bit linger, input logic [31:0] lit_data, input logic [1:0] lit_err);
        exp_t e;
        int   start;
        wait_ready();
        e = model(st, f3, addr, wd, stall);
        req_valid = 1'b1;
        req_store = st;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wd;
        start     = done_cnt;
        @(posedge clk);
        #1;
        e.due = (cyc - 1) + e.due;
        exp_q.push_back(e);
        if (linger) begin
            // Request seen while busy: must be ignored.
            req_store = 1'b1;
            req_f3    = 3'd2;
            req_addr  = 32'h40;
            req_wdata = 32'h0BADF00D;
        end else begin
            req_valid = 1'b0;
        end
        if (stall > 0) begin
            if (st) wr_ready = 1'b0;
            else    rd_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            wr_ready = 1'b1;
            rd_ready = 1'b1;
        end
        if (linger) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        for (int k = 0; k < 40 && done_cnt == start; k++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == start) fail_now({name, "_no_resp"});
        check({name, "_data"}, 64'(last_data), 64'(lit_data));
        check({name, "_err"}, 64'(last_err), 64'(lit_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_f3    = 3'd2;
        req_addr  = 32'h10;
        req_wdata = 32'h12345678;
        rd_ready  = 1'b1;
        wr_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 64'(req_ready), 64'd1);
        check("post_reset_resp", {resp_valid, resp_err, resp_data}, 64'd0);
        @(posedge clk);
        #1;

        // store, then load the same word back
        do_req("sw_10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0,        2'b00);
        do_req("lw_10",  1'b0, 3'd2, 32'h10, 32'h0,        0, 1'b0, 32'hDEADBEEF, 2'b00);

        // sign and zero extension against word 0x20 = 0x80FF7F81
        do_req("lb_20",  1'b0, 3'd0, 32'h20, 32'h0, 0, 1'b0, 32'hFFFFFF81, 2'b00);
        do_req("lbu_20", 1'b0, 3'd4, 32'h20, 32'h0, 0, 1'b0, 32'h00000081, 2'b00);
        do_req("lh_22",  1'b0, 3'd1, 32'h22, 32'h0, 0, 1'b0, 32'hFFFF80FF, 2'b00);
        do_req("lhu_22", 1'b0, 3'd5, 32'h22, 32'h0, 0, 1'b0, 32'h000080FF, 2'b00);
        do_req("lb_21",  1'b0, 3'd0, 32'h21, 32'h0, 0, 1'b0, 32'h0000007F, 2'b00);

        // byte store into the top lane
        do_req("sb_23",  1'b1, 3'd0, 32'h23, 32'h123456AA, 0, 1'b0, 32'h0,        2'b00);
        do_req("lw_20",  1'b0, 3'd2, 32'h20, 32'h0,        0, 1'b0, 32'hAAFF7F81, 2'b00);

        // error classification and priority
        do_req("lh_21",  1'b0, 3'd1, 32'h21,  32'h0,        0, 1'b0, 32'h0, 2'b01);
        do_req("sw_402", 1'b1, 3'd2, 32'h402, 32'h11111111, 0, 1'b0, 32'h0, 2'b01);
        do_req("lw_400", 1'b0, 3'd2, 32'h400, 32'h0,        0, 1'b0, 32'h0, 2'b10);
        do_req("ld_f3_3",1'b0, 3'd3, 32'h20,  32'h0,        0, 1'b0, 32'h0, 2'b11);
        do_req("st_f3_4",1'b1, 3'd4, 32'h20,  32'h22222222, 0, 1'b0, 32'h0, 2'b11);

        // memory back-pressure on both ports
        do_req("sw_stall", 1'b1, 3'd2, 32'h14, 32'hCAFEF00D, 3, 1'b0, 32'h0,        2'b00);
        do_req("lw_stall", 1'b0, 3'd2, 32'h14, 32'h0,        2, 1'b0, 32'hCAFEF00D, 2'b00);

        // half store into the upper half
        do_req("sh_16",  1'b1, 3'd1, 32'h16, 32'hFFFF1234, 0, 1'b0, 32'h0,        2'b00);
        do_req("lw_14",  1'b0, 3'd2, 32'h14, 32'h0,        0, 1'b0, 32'h1234F00D, 2'b00);

        // valid held high while busy must not start a second access
        do_req("lw_linger", 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b1, 32'hDEADBEEF, 2'b00);

        // reset asserted in the write cycle aborts the store
        wait_ready();
        req_valid = 1'b1;
        req_store = 1'b1;
        req_f3    = 3'd2;
        req_addr  = 32'h30;
        req_wdata = 32'h55555555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_mem_word",
              {dev_mem[32'h33], dev_mem[32'h32], dev_mem[32'h31], dev_mem[32'h30]},
              64'h11223344);
        do_req("lw_30_after_abort", 1'b0, 3'd2, 32'h30, 32'h0, 0, 1'b0, 32'h11223344, 2'b00);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
